// File: rtl/prefix_fill_if.sv
// Handshake and side-read bus for the prefix_fill kernel.
// The slave modport is the kernel side. The master modport is the side that starts runs and reads the array.
interface prefix_fill_if;
    logic               r_enable;
    logic [63:0]        init_i;
    logic signed [63:0] init_acc;
    logic               w_enable;
    logic [63:0]        result;
    logic [9:0]         rd_addr;
    logic signed [31:0] rd_data;

    modport master (
        output r_enable, init_i, init_acc, rd_addr,
        input  w_enable, result, rd_data
    );

    modport slave (
        input  r_enable, init_i, init_acc, rd_addr,
        output w_enable, result, rd_data
    );
endinterface

// File: rtl/prefix_fill.sv
// Prefix-sum writer: walks i from init_i to N_ELEM-1 and stores every partial sum in mem[i].
// When the walk ends, the final 64-bit sum is presented on result and w_enable goes high.
//
// state | meaning
// IDLE  | waiting for a start pulse
// CHECK | loop test of i against N_ELEM
// STEP  | accumulate, write partial sum, advance i
// DONE  | result valid, w_enable held high
module prefix_fill #(
    parameter int N_ELEM = 1000
) (
    input logic          clk,
    input logic          rst,
    prefix_fill_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, STEP, DONE} state_t;

    state_t             state;
    logic [63:0]        i;
    logic signed [63:0] acc;
    logic [63:0]        sum;
    logic               mem_we;

    // Contents persist across rst; only time zero clears the array.
    logic signed [31:0] mem [N_ELEM] = '{default: '0};

    assign sum    = acc + i;
    assign mem_we = (state == STEP) && !rst && !bus.r_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.w_enable <= 1'b0;
            bus.result   <= '0;
            i            <= '0;
            acc          <= '0;
        end else if (bus.r_enable) begin
            i            <= bus.init_i;
            acc          <= bus.init_acc;
            bus.w_enable <= 1'b0;
            state        <= CHECK;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                CHECK: begin
                    if (i >= 64'(N_ELEM)) state <= DONE;
                    else                  state <= STEP;
                end
                STEP: begin
                    acc   <= sum;
                    i     <= i + 64'd1;
                    state <= CHECK;
                end
                DONE: begin
                    bus.w_enable <= 1'b1;
                    bus.result   <= acc;
                    state        <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Kept apart from the reset block so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[i[9:0]] <= sum[31:0];
    end

    assign bus.rd_data = (bus.rd_addr < 10'(N_ELEM)) ? mem[bus.rd_addr] : '0;
endmodule

// File: tb/tb_prefix_fill.sv
// Directed bench for prefix_fill. It checks edge-exact done timing, result values and array contents.
module tb_prefix_fill;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    prefix_fill_if bus ();

    prefix_fill #(.N_ELEM(1000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag, input logic [9:0] addr, input logic [31:0] exp);
        bus.rd_addr = addr;
        #1;
        check(tag, {32'b0, bus.rd_data}, {32'b0, exp});
    endtask

    // Returns just after edge 0, the edge that samples r_enable.
    task automatic start(input logic [63:0] ii, input logic [63:0] aa);
        bus.init_i   = ii;
        bus.init_acc = aa;
        bus.r_enable = 1'b1;
        tick();
        bus.r_enable = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.r_enable = 1'b0;
        bus.init_i   = '0;
        bus.init_acc = '0;
        bus.rd_addr  = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_w_enable", {63'b0, bus.w_enable}, 64'd0);
        check("reset_result", bus.result, 64'd0);
        chk_mem("init_mem5", 10'd5, 32'd0);

        // Reset lands on edge 10 of a run from 0: only mem[0..3] are written.
        start(64'd0, 64'd0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_abort_w", {63'b0, bus.w_enable}, 64'd0);
        check("rst_abort_result", bus.result, 64'd0);
        repeat (10) tick();
        check("rst_idle_w", {63'b0, bus.w_enable}, 64'd0);
        chk_mem("rst_mem3", 10'd3, 32'd6);
        chk_mem("rst_mem4", 10'd4, 32'd0);
        chk_mem("rst_mem5", 10'd5, 32'd0);

        // Full run from 0.
        start(64'd0, 64'd0);
        repeat (2001) tick();
        check("full_w_edge2001", {63'b0, bus.w_enable}, 64'd0);
        tick();
        check("full_w_edge2002", {63'b0, bus.w_enable}, 64'd1);
        check("full_result", bus.result, 64'd499500);
        chk_mem("full_mem0", 10'd0, 32'd0);
        chk_mem("full_mem3", 10'd3, 32'd6);
        chk_mem("full_mem999", 10'd999, 32'd499500);
        chk_mem("oob_read", 10'd1000, 32'd0);

        // Back-to-back partial run: 997 with acc -5.
        start(64'd997, -64'sd5);
        check("b2b_w_drop", {63'b0, bus.w_enable}, 64'd0);
        check("b2b_result_hold", bus.result, 64'd499500);
        bus.rd_addr = 10'd997;
        tick();
        chk_mem("same_cycle_old", 10'd997, 32'd497503);
        tick();
        chk_mem("after_write_new", 10'd997, 32'd992);
        repeat (5) tick();
        check("part_w_edge7", {63'b0, bus.w_enable}, 64'd0);
        tick();
        check("part_w_edge8", {63'b0, bus.w_enable}, 64'd1);
        check("part_result", bus.result, 64'd2989);
        chk_mem("part_mem998", 10'd998, 32'd1990);
        chk_mem("part_mem999", 10'd999, 32'd2989);
        chk_mem("part_mem996", 10'd996, 32'd496506);

        // Empty runs.
        start(64'd1000, 64'd42);
        tick();
        check("empty_w_edge1", {63'b0, bus.w_enable}, 64'd0);
        tick();
        check("empty_w_edge2", {63'b0, bus.w_enable}, 64'd1);
        check("empty_result", bus.result, 64'd42);
        chk_mem("empty_mem999", 10'd999, 32'd2989);
        start(64'h8000_0000_0000_0000, 64'd42);
        check("huge_w_drop", {63'b0, bus.w_enable}, 64'd0);
        tick();
        tick();
        check("huge_w_edge2", {63'b0, bus.w_enable}, 64'd1);
        check("huge_result", bus.result, 64'd42);
        chk_mem("huge_mem997", 10'd997, 32'd992);

        // Truncation of the stored low word.
        start(64'd999, 64'h0000_0001_7FFF_FFFF);
        repeat (3) tick();
        check("trunc_w_edge3", {63'b0, bus.w_enable}, 64'd0);
        tick();
        check("trunc_w_edge4", {63'b0, bus.w_enable}, 64'd1);
        check("trunc_result", bus.result, 64'h0000_0001_8000_03E6);
        chk_mem("trunc_mem999", 10'd999, 32'h8000_03E6);
        check("trunc_sign", {{32{bus.rd_data[31]}}, bus.rd_data}, 64'hFFFF_FFFF_8000_03E6);

        // Restart on edge 10 of a run from 0 with init_i 998.
        start(64'd0, 64'd0);
        repeat (9) tick();
        bus.init_i   = 64'd998;
        bus.init_acc = 64'd0;
        bus.r_enable = 1'b1;
        tick();
        bus.r_enable = 1'b0;
        repeat (5) tick();
        check("restart_w_edge15", {63'b0, bus.w_enable}, 64'd0);
        tick();
        check("restart_w_edge16", {63'b0, bus.w_enable}, 64'd1);
        check("restart_result", bus.result, 64'd1997);
        chk_mem("restart_mem998", 10'd998, 32'd998);
        chk_mem("restart_mem999", 10'd999, 32'd1997);
        chk_mem("restart_mem4", 10'd4, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
